snes_reader: RTL and testbench
==============================

# snes_reader

Console-side SNES controller poller. It drives latch and serial clock to a physical SNES controller and shifts in the 16-bit serial report. It presents the report as active-high button bits with a one-cycle update strobe. It is the initiator for the same protocol `snes_encoder` answers, so a real pad can feed the multiplexer beside the keyboard, IR and button-board paths.

## Interface
Parameters:
- `HALF_CNT`, 12: clk cycles per serial-clock half period (~5.8 us at 2.08 MHz); must be >= 4.
- `LATCH_CNT`, 24: clk cycles latch is held high (~11.5 us).
- `POLL_CNT`, 34667: clk cycles between transaction starts (~16.7 ms); must exceed the transaction length.

Ports:
- `clk` in 1: system clock (2.08 MHz oscillator domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `pad_data` in 1: controller serial data, active-low, asynchronous, externally pulled up.
- `pad_latch` out 1: latch to controller, active-high.
- `pad_clk` out 1: serial clock to controller, idles high.
- `buttons` out 12: active-high, bit0..11 = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- `raw` out 16: full inverted report, bit i = serial bit i.
- `valid` out 1: one-cycle pulse when `buttons`/`raw` update.
- `present` out 1: controller detected (see Configuration).

## Operation
- `pad_data` passes through a 2-flop synchronizer; only the synchronized value is sampled.
- Poll counter runs 0..POLL_CNT-1 and wraps, free-running from reset release. A transaction starts when the counter equals POLL_CNT-1.
- FSM states:
  - IDLE: latch 0, clk 1. Go to LATCH on poll tick.
  - LATCH: latch 1 for LATCH_CNT cycles, then go to LOW with bit index 0.
  - LOW: clk 0 for HALF_CNT cycles. On the last cycle, shift in `~sync_data` as bit[index], then go to HIGH.
  - HIGH: clk 1 for HALF_CNT cycles. The controller advances on the rising edge. On the last cycle, if index = last, go to DONE; else index+1 and go to LOW.
  - DONE: one cycle. Load outputs from the shift register, pulse `valid`, go to IDLE.
- Last index is 15, or 16 with SNES_READER_PRESENT_EN.
- `buttons` = `raw[11:0]`; `raw[15:12]` is passed through unmodified.
- Outputs hold between updates. The shift register is internal, so a partial report is never visible.
- A poll tick that arrives while not in IDLE is ignored; parameter rules make this impossible.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `buttons`=0, `raw`=0, `valid`=0, `present`=0. FSM goes to IDLE, counters to 0.
- First latch rises POLL_CNT cycles after reset deasserts.
- Transaction length with defaults:
  - Latch phase: 24 cycles.
  - Clock phase: 16×24 = 384 cycles, or 17×24 = 408 with the macro.
  - `valid` asserts 1 cycle after the final HIGH phase ends.
- `pad_latch` and `pad_clk` are registered outputs, glitch-free, and never both transition in the same cycle.
- Input-to-sample latency is 2 cycles. The controller must settle within HALF_CNT-3 cycles of a clk edge.
- Reset asserted mid-transaction: all outputs immediately (asynchronously) take their reset values. The partial report is discarded.

## Configuration
- `SNES_READER_PRESENT_EN` defined:
  - Adds a 17th clock pulse; the sampled bit 16 is not inverted.
  - A standard pad drives bit 16 low, so `present`=1; a pulled-up line reads 1, so `present`=0. `present` updates on `valid`.
  - While `present`=0, `buttons` and `raw` load 0.
- Not defined: 16 pulses only, `present` tied to 1 after reset release.

## Test plan
- Reset, hold `pad_data`=1 → `pad_latch` rises at cycle 34667 for 24 cycles. 16 low pulses of 12 cycles follow. `valid` pulses once with `buttons`=0 and `raw`=0.
- Pad model serializes report 0xFFFE (B pressed, low on bit 0) → `buttons`=12'h001, `raw`=16'h0001.
- Pad model with Start and R pressed, bits 12-15 high → `buttons`=12'h808, `raw[15:12]`=0.
- Assert `reset_n` low during pulse 7 → `pad_clk`=1, `pad_latch`=0 and `buttons`=0 asynchronously. After release, the next latch arrives POLL_CNT cycles later.
- Macro on, pad drives bit 16 low → 17 pulses, `present`=1. Release `pad_data` high → next `valid` gives `present`=0 and `buttons`=0.
- Two consecutive polls → `valid` pulses exactly POLL_CNT cycles apart. `pad_latch` and `pad_clk` never change in the same cycle.

Source files
------------

// File: rtl/snes_reader.sv
// SNES controller poller: strobes latch, clocks out the 16-bit serial report and publishes active-high buttons.
// Optional macro SNES_READER_PRESENT_EN adds a 17th pulse whose bit detects an attached pad.
module snes_reader #(
  parameter int HALF_CNT  = 12,
  parameter int LATCH_CNT = 24,
  parameter int POLL_CNT  = 34667
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [11:0] buttons,
  output logic [15:0] raw,
  output logic        valid,
  output logic        present
);

`ifdef SNES_READER_PRESENT_EN
  localparam int LAST_IDX = 16;
`else
  localparam int LAST_IDX = 15;
`endif
  localparam int SHIFT_W = LAST_IDX + 1;
  localparam int IDX_W   = 5;
  localparam int POLL_W  = $clog2(POLL_CNT);
  localparam int PHASE_W = $clog2((LATCH_CNT > HALF_CNT) ? LATCH_CNT : HALF_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [POLL_W-1:0]    r_poll;
  logic [PHASE_W-1:0]   r_phase;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [SHIFT_W-1:0]   r_shift;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_pollTick;
  logic                 w_phaseEnd;
  logic                 w_lastBit;
  logic                 w_sampleBit;
  logic                 w_present;
  logic [15:0]          w_rawNext;

  assign w_pollTick = (r_poll == POLL_W'(POLL_CNT - 1));
  assign w_lastBit  = (r_bitIdx == IDX_W'(LAST_IDX));

`ifdef SNES_READER_PRESENT_EN
  // The presence bit is taken as-is: a real pad pulls it low, an empty port reads high.
  assign w_sampleBit = w_lastBit ? r_sync2 : ~r_sync2;
  assign w_present   = ~r_shift[16];
  assign w_rawNext   = w_present ? r_shift[15:0] : 16'h0000;
`else
  assign w_sampleBit = ~r_sync2;
  assign w_present   = 1'b1;
  assign w_rawNext   = r_shift[15:0];
`endif

  always_comb begin
    w_phaseEnd = 1'b0;
    w_next     = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pollTick) w_next = S_LATCH;
      end
      S_LATCH: begin
        w_phaseEnd = (r_phase == PHASE_W'(LATCH_CNT - 1));
        if (w_phaseEnd) w_next = S_LOW;
      end
      S_LOW: begin
        w_phaseEnd = (r_phase == PHASE_W'(HALF_CNT - 1));
        if (w_phaseEnd) w_next = S_HIGH;
      end
      S_HIGH: begin
        w_phaseEnd = (r_phase == PHASE_W'(HALF_CNT - 1));
        if (w_phaseEnd) w_next = w_lastBit ? S_DONE : S_LOW;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_poll   <= '0;
      r_phase  <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_sync1 <= pad_data;
      r_sync2 <= r_sync1;
      r_poll  <= w_pollTick ? '0 : r_poll + POLL_W'(1);
      r_phase <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_phase + PHASE_W'(1);
      if (r_state == S_LATCH) begin
        r_bitIdx <= '0;
      end else if (r_state == S_HIGH && w_phaseEnd && !w_lastBit) begin
        r_bitIdx <= r_bitIdx + IDX_W'(1);
      end
      // LSB-first right shift: after the last sample, bit i holds serial bit i.
      if (r_state == S_LOW && w_phaseEnd) begin
        r_shift <= {w_sampleBit, r_shift[SHIFT_W-1:1]};
      end
    end
  end

  // pad_clk follows the state one cycle late so it never moves on the same edge as pad_latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      buttons   <= '0;
      raw       <= '0;
      valid     <= 1'b0;
      present   <= 1'b0;
    end else begin
      pad_latch <= (w_next == S_LATCH);
      pad_clk   <= (r_state != S_LOW);
      valid     <= (r_state == S_DONE);
`ifdef SNES_READER_PRESENT_EN
      if (r_state == S_DONE) present <= w_present;
`else
      present <= w_present;
`endif
      if (r_state == S_DONE) begin
        raw     <= w_rawNext;
        buttons <= w_rawNext[11:0];
      end
    end
  end

endmodule

// File: tb/tb_snes_reader.sv
// Self-checking bench for snes_reader: a pad model serializes reports and a scoreboard checks each valid.
// Expectations track SNES_READER_PRESENT_EN when the bench is built with the macro.
module tb_snes_reader;

  localparam int HALF  = 12;
  localparam int LATCH = 24;
  localparam int POLL  = 600;
`ifdef SNES_READER_PRESENT_EN
  localparam int  NPULSE   = 17;
  localparam bit  MACRO_ON = 1'b1;
`else
  localparam int  NPULSE   = 16;
  localparam bit  MACRO_ON = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        pad_data = 1'b1;
  logic        pad_latch;
  logic        pad_clk;
  logic [11:0] buttons;
  logic [15:0] raw;
  logic        valid;
  logic        present;

  snes_reader #(
    .HALF_CNT (HALF),
    .LATCH_CNT(LATCH),
    .POLL_CNT (POLL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .raw      (raw),
    .valid    (valid),
    .present  (present)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] buttons;
    logic [15:0] raw;
    logic        present;
  } exp_t;

  exp_t        expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleCnt    = 0;
  logic [15:0] report      = 16'hFFFF;
  logic        extraBit    = 1'b1;
  logic [16:0] padWord     = '1;
  int          padIdx      = 0;
  int          latchRises  = 0;
  int          latchRiseCycle = 0;
  int          validCount  = 0;
  int          lastValidCycle = -1;
  int          pulses      = 0;
  int          lowRun      = 0;
  int          latchRun    = 0;
  int          skewCount   = 0;
  int          badWidth    = 0;
  int          multiValid  = 0;
  logic        prevClk     = 1'b1;
  logic        prevLatch   = 1'b0;
  logic        prevValid   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] rep, input logic ext);
    report   = rep;
    extraBit = ext;
  endtask

  function automatic exp_t predict(input logic [15:0] rep, input logic ext);
    exp_t        e;
    logic [15:0] r;
    r         = ~rep;
    e.present = 1'b1;
    if (MACRO_ON) begin
      e.present = ~ext;
      if (ext) r = 16'h0000;
    end
    e.raw     = r;
    e.buttons = r[11:0];
    return e;
  endfunction

  always @(posedge clk) cycleCnt++;

  always @(negedge reset_n) expQ.delete();

  // Pad model: latch loads the word and presents bit 0; each rising pad_clk advances one bit.
  always @(posedge pad_latch) begin
    padWord        = {extraBit, report};
    padIdx         = 0;
    pad_data       = padWord[0];
    latchRises++;
    latchRiseCycle = cycleCnt;
    expQ.push_back(predict(report, extraBit));
  end

  always @(posedge pad_clk) begin
    if (reset_n && !pad_latch) begin
      padIdx++;
      pad_data = (padIdx < 17) ? padWord[padIdx] : extraBit;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      lowRun         = 0;
      latchRun       = 0;
      lastValidCycle = -1;
    end else begin
      if (pad_clk !== prevClk && pad_latch !== prevLatch) skewCount++;
      if (pad_latch && !prevLatch) begin
        pulses   = 0;
        latchRun = 0;
      end
      if (pad_latch) latchRun++;
      else if (prevLatch) checkOutput("latchWidth", latchRun, LATCH);
      if (!pad_clk) begin
        if (prevClk) pulses++;
        lowRun++;
      end else if (!prevClk) begin
        if (lowRun != HALF) badWidth++;
        lowRun = 0;
      end
      if (valid && prevValid) multiValid++;
      if (valid) begin
        checkOutput("sbHasEntry", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("buttons", buttons, e.buttons);
          checkOutput("raw", raw, e.raw);
          checkOutput("present", present, e.present);
        end
        checkOutput("pulseCount", pulses, NPULSE);
        if (lastValidCycle >= 0) checkOutput("validInterval", cycleCnt - lastValidCycle, POLL);
        lastValidCycle = cycleCnt;
        validCount++;
      end
    end
    prevClk   = pad_clk;
    prevLatch = pad_latch;
    prevValid = valid;
  end

  task automatic waitValid(input int budget);
    int target;
    int n;
    target = validCount + 1;
    n = 0;
    while (validCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("validTimeout", validCount >= target, 1);
  endtask

  task automatic waitLatch(input int startRises, input int budget);
    int n;
    n = 0;
    while (latchRises <= startRises && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latchTimeout", latchRises > startRises, 1);
  endtask

  initial begin
    int releaseCycle;
    int rises0;
    int n;

    applyStimulus(16'hFFFF, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("rstLatch", pad_latch, 0);
    checkOutput("rstPadClk", pad_clk, 1);
    checkOutput("rstButtons", buttons, 0);
    checkOutput("rstRaw", raw, 0);
    checkOutput("rstValid", valid, 0);
    checkOutput("rstPresent", present, 0);

    @(negedge clk);
    reset_n      = 1'b1;
    releaseCycle = cycleCnt;
    rises0       = latchRises;
    waitLatch(rises0, POLL + 20);
    checkOutput("firstLatch", latchRiseCycle - releaseCycle, POLL);
    waitValid(POLL);

    applyStimulus(16'hFFFE, 1'b0);
    waitValid(POLL + 20);
    applyStimulus(16'hF7F7, 1'b0);
    waitValid(POLL + 20);
    applyStimulus(16'h0000, 1'b1);
    waitValid(POLL + 20);
    applyStimulus(16'hA5C3, 1'b0);
    waitValid(POLL + 20);

    applyStimulus(16'h6FBD, 1'b0);
    rises0 = latchRises;
    n = 0;
    while (!(latchRises > rises0 && pulses == 7) && n < POLL + 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pulse7Timeout", pulses, 7);
    checkOutput("preRstPadClk", pad_clk, 0);
    checkOutput("preRstButtons", buttons, 12'hA3C);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstPadClk", pad_clk, 1);
    checkOutput("midRstLatch", pad_latch, 0);
    checkOutput("midRstButtons", buttons, 0);
    checkOutput("midRstRaw", raw, 0);
    checkOutput("midRstPresent", present, 0);

    repeat (3) @(negedge clk);
    reset_n      = 1'b1;
    releaseCycle = cycleCnt;
    rises0       = latchRises;
    waitLatch(rises0, POLL + 20);
    checkOutput("latchAfterReset", latchRiseCycle - releaseCycle, POLL);
    waitValid(POLL);

    repeat (5) @(negedge clk);
    checkOutput("latchClkSameEdge", skewCount, 0);
    checkOutput("lowPulseWidth", badWidth, 0);
    checkOutput("validWidth", multiValid, 0);
    checkOutput("sbLeftover", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
